// File: rtl/cpu_dma_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_dma_engine_pkg
// Description : Shared definitions for the CPU-bus DMA engine: FSM state
//               encoding, bus direction constants and default addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_dma_engine_pkg;

    // Engine states, explicitly encoded on 3 bits.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HALT      = 3'd1,
        ST_ALIGN     = 3'd2,
        ST_DMC_READ  = 3'd3,
        ST_BLK_READ  = 3'd4,
        ST_BLK_WRITE = 3'd5
    } dma_state_t;

    // Bus direction values shared with the CPU core.
    localparam logic c_RW_READ  = 1'b1;
    localparam logic c_RW_WRITE = 1'b0;

    // Default trigger register and block destination port.
    localparam logic [15:0] c_DEF_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] c_DEF_DEST_ADDR = 16'h2004;

    // Block index width: one bit more than a page so 256 is representable.
    localparam int c_IDX_W = 9;

endpackage
`default_nettype wire

// File: rtl/cpu_dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : cpu_dma_engine
// Description : Bus-mastering DMA engine for the CPU bus. Snoops writes to a
//               trigger register, halts the CPU and copies a block from a
//               page to a fixed port; also serves single-byte sample fetches
//               with priority over the block copy.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_dma_engine
    import cpu_dma_engine_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter int                XFER_LEN  = 256,
    parameter logic [ADDR_W-1:0] TRIG_ADDR = ADDR_W'(c_DEF_TRIG_ADDR),
    parameter logic [ADDR_W-1:0] DEST_ADDR = ADDR_W'(c_DEF_DEST_ADDR)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data_out,
    input  logic              cpu_rw,
    output logic              rdy,
    output logic              dma_owns_bus,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data_out,
    output logic              bus_rw,
    input  logic [DATA_W-1:0] data_in,
    input  logic              dmc_req,
    input  logic [ADDR_W-1:0] dmc_addr,
    output logic              dmc_ack,
    output logic [DATA_W-1:0] dmc_data,
    output logic              busy
);

    dma_state_t         r_state;
    dma_state_t         w_state_nxt;
    dma_state_t         w_get_target;
    logic               r_parity;
    logic               r_busy;
    logic [DATA_W-1:0]  r_page;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] w_idx_inc;
    logic [DATA_W-1:0]  r_buf;
    logic [DATA_W-1:0]  r_dmc_data;
    logic               w_trigger;
    logic               w_last;

    // The DMA only leaves the CPU on the bus in IDLE and HALT, so only there
    // can a CPU write be seen; a trigger while a block is running is dropped.
    assign w_trigger = !r_busy && (cpu_rw == c_RW_WRITE) && (cpu_addr == TRIG_ADDR)
                       && ((r_state == ST_IDLE) || (r_state == ST_HALT));
    assign w_idx_inc = r_idx + c_IDX_W'(1);
    assign w_last    = (w_idx_inc == c_IDX_W'(XFER_LEN));

    // Where to go when the next cycle is a get cycle: DMC wins over the block.
    assign w_get_target = dmc_req ? ST_DMC_READ : (r_busy ? ST_BLK_READ : ST_IDLE);

    assign busy     = r_busy;
    assign dmc_data = (r_state == ST_DMC_READ) ? data_in : r_dmc_data;

    // State register and get/put parity.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_parity <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_parity <= ~r_parity;
        end
    end

    // Block bookkeeping: busy flag, source page and byte index.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_page <= '0;
            r_idx  <= '0;
        end else if (w_trigger) begin
            r_busy <= 1'b1;
            r_page <= cpu_data_out;
            r_idx  <= '0;
        end else if (r_state == ST_BLK_WRITE) begin
            r_idx <= w_idx_inc;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Data capture: block byte on its read, sample byte on its fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_buf      <= '0;
            r_dmc_data <= '0;
        end else begin
            if (r_state == ST_BLK_READ) begin
                r_buf <= data_in;
            end
            if (r_state == ST_DMC_READ) begin
                r_dmc_data <= data_in;
            end
        end
    end

    // Next state and bus outputs. HALT leaves only on a CPU read cycle, and
    // goes through ALIGN when the following cycle would be a put cycle.
    always_comb begin
        w_state_nxt  = r_state;
        rdy          = 1'b0;
        dma_owns_bus = 1'b0;
        bus_addr     = '0;
        bus_data_out = '0;
        bus_rw       = c_RW_READ;
        dmc_ack      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                rdy = 1'b1;
                if (w_trigger || dmc_req) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (cpu_rw == c_RW_READ) begin
                    w_state_nxt = r_parity ? w_get_target : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                dma_owns_bus = 1'b1;
                bus_addr     = cpu_addr;
                w_state_nxt  = w_get_target;
            end
            ST_DMC_READ: begin
                dma_owns_bus = 1'b1;
                bus_addr     = dmc_addr;
                dmc_ack      = 1'b1;
                // Resuming the block needs one put cycle to realign.
                w_state_nxt  = r_busy ? ST_ALIGN : ST_IDLE;
            end
            ST_BLK_READ: begin
                dma_owns_bus = 1'b1;
                bus_addr     = ADDR_W'({r_page, r_idx[7:0]});
                w_state_nxt  = ST_BLK_WRITE;
            end
            ST_BLK_WRITE: begin
                dma_owns_bus = 1'b1;
                bus_addr     = DEST_ADDR;
                bus_rw       = c_RW_WRITE;
                bus_data_out = r_buf;
                w_state_nxt  = w_last ? ST_IDLE : w_get_target;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_dma_engine
// Description : Self-checking bench for cpu_dma_engine. Random memory and
//               pages; expected transfers, cycle counts and DMC results are
//               derived from the block-copy rules in a simple model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_dma_engine;

    localparam int          LEN    = 256;
    localparam logic [15:0] TRIG   = 16'h4014;
    localparam logic [15:0] DEST   = 16'h2004;
    localparam logic [15:0] IDLE_A = 16'h8123;
    localparam logic [15:0] DMC_A  = 16'hC000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = IDLE_A;
    logic [7:0]  cpu_data_out = 8'h00;
    logic        cpu_rw = 1'b1;
    logic        rdy, dma_owns_bus, bus_rw, dmc_ack, busy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out, data_in, dmc_data;
    logic        dmc_req = 1'b0;
    logic [15:0] dmc_addr = DMC_A;

    logic [7:0]  mem [0:65535];
    logic [7:0]  wr_q [$];
    logic [15:0] rd_q [$];
    int busy_cnt = 0, rdylo_cnt = 0, own_cnt = 0, steal_cnt = 0, bad_dest = 0;
    int align_cnt = 0, ack_cnt = 0, last_ack_cyc = 0, ncyc = 0;
    logic [7:0] last_dmc_data = 8'h00;
    bit tb_par = 1'b0;
    int n_checks = 0, n_errors = 0;

    cpu_dma_engine #(
        .ADDR_W(16), .DATA_W(8), .XFER_LEN(LEN), .TRIG_ADDR(TRIG), .DEST_ADDR(DEST)
    ) dut (
        .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
        .cpu_rw(cpu_rw), .rdy(rdy), .dma_owns_bus(dma_owns_bus), .bus_addr(bus_addr),
        .bus_data_out(bus_data_out), .bus_rw(bus_rw), .data_in(data_in),
        .dmc_req(dmc_req), .dmc_addr(dmc_addr), .dmc_ack(dmc_ack), .dmc_data(dmc_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Memory answers whoever owns the bus.
    assign data_in = mem[dma_owns_bus ? bus_addr : cpu_addr];

    // Parity of the current cycle: 0 right after a reset edge, then alternating.
    always @(posedge clock) tb_par <= reset ? 1'b0 : ~tb_par;

    // Bus observer: classifies every DMA-owned cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (busy === 1'b1) busy_cnt++;
            if (rdy === 1'b0) rdylo_cnt++;
            if (dma_owns_bus === 1'b1) begin
                own_cnt++;
                if (cpu_rw == 1'b0) steal_cnt++;
                if (bus_rw !== 1'b1) begin
                    wr_q.push_back(bus_data_out);
                    if (bus_addr !== DEST) bad_dest++;
                end else if (dmc_ack === 1'b1) begin
                    ack_cnt++;
                    last_dmc_data = dmc_data;
                    last_ack_cyc  = ncyc;
                end else if (bus_addr == cpu_addr) begin
                    align_cnt++;
                end else begin
                    rd_q.push_back(bus_addr);
                end
            end else if (dmc_ack === 1'b1) begin
                ack_cnt++;
            end
        end
        ncyc++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Trigger a block copy on a chosen parity, optionally with nwr CPU writes
    // (aimed at the trigger register, which must be ignored) during HALT and a
    // DMC request mid-block, then compare against the model.
    task automatic run_block(input logic [7:0] page, input bit want_par,
                             input int nwr, input bit with_dmc);
        int wb, rb, bb, lb, ab, sb, db, kb, guard, exp_busy, exp_align;
        bit p_trig, p_halt_end;
        logic [7:0] dval, i8;
        if (tb_par != want_par) step();
        wb = wr_q.size(); rb = rd_q.size(); bb = busy_cnt; lb = rdylo_cnt;
        ab = align_cnt; sb = steal_cnt; db = bad_dest; kb = ack_cnt;
        p_trig = tb_par;
        dval = 8'($urandom);
        mem[DMC_A] = dval;
        dmc_addr = DMC_A;
        cpu_rw = 1'b0; cpu_addr = TRIG; cpu_data_out = page;
        step();
        for (int i = 0; i < nwr; i++) begin
            cpu_addr = TRIG; cpu_data_out = ~page;
            step();
        end
        cpu_rw = 1'b1; cpu_addr = IDLE_A; cpu_data_out = 8'h00;
        if (with_dmc) begin
            guard = 0;
            while ((wr_q.size() - wb) < 16 && guard < 2000) begin step(); guard++; end
            dmc_req = 1'b1;
            guard = 0;
            while (ack_cnt == kb && guard < 20) begin step(); guard++; end
            dmc_req = 1'b0;
        end
        guard = 0;
        while (busy === 1'b1 && guard < 3000) begin step(); guard++; end
        chk("blk_done_in_time", 32'(guard < 3000), 32'd1);

        // HALT spans the trigger-following cycle plus one per CPU write; an
        // ALIGN is needed when the last HALT cycle is a get cycle.
        p_halt_end = p_trig ^ bit'((1 + nwr) % 2);
        exp_align  = (p_halt_end == 1'b0) ? 1 : 0;
        exp_busy   = 1 + nwr + exp_align + 2 * LEN + (with_dmc ? 2 : 0);

        chk("blk_busy_cycles", 32'(busy_cnt - bb), 32'(exp_busy));
        chk("blk_rdy_low_cycles", 32'(rdylo_cnt - lb), 32'(exp_busy));
        chk("blk_align_cycles", 32'(align_cnt - ab), 32'(exp_align + int'(with_dmc)));
        chk("blk_write_count", 32'(wr_q.size() - wb), 32'(LEN));
        chk("blk_read_count", 32'(rd_q.size() - rb), 32'(LEN));
        for (int i = 0; i < LEN; i++) begin
            i8 = 8'(i);
            if (wb + i < wr_q.size()) chk("blk_wr_data", 32'(wr_q[wb+i]), 32'(mem[{page, i8}]));
            if (rb + i < rd_q.size()) chk("blk_rd_addr", 32'(rd_q[rb+i]), 32'({page, i8}));
        end
        chk("blk_cpu_write_stolen", 32'(steal_cnt - sb), 32'd0);
        chk("blk_bad_dest", 32'(bad_dest - db), 32'd0);
        chk("blk_dmc_acks", 32'(ack_cnt - kb), 32'(with_dmc));
        if (with_dmc) chk("blk_dmc_data", 32'(last_dmc_data), 32'(dval));
        @(negedge clock);
        chk("blk_rdy_after", 32'(rdy), 32'd1);
        chk("blk_busy_after", 32'(busy), 32'd0);
        step();
    endtask

    // Standalone sample fetch: halt, optional align, one read.
    task automatic run_dmc(input logic [15:0] a);
        int req_c, guard, kb, bb, rb;
        bit p;
        logic [7:0] v;
        if ($urandom_range(0, 1) == 1) step();
        v = 8'($urandom);
        mem[a] = v;
        kb = ack_cnt; bb = busy_cnt; rb = rd_q.size();
        req_c = ncyc;
        p = tb_par;
        dmc_addr = a; dmc_req = 1'b1;
        guard = 0;
        while (ack_cnt == kb && guard < 20) begin step(); guard++; end
        dmc_req = 1'b0;
        chk("dmc_ack_count", 32'(ack_cnt - kb), 32'd1);
        chk("dmc_data", 32'(last_dmc_data), 32'(v));
        chk("dmc_latency", 32'(last_ack_cyc - req_c), p ? 32'd3 : 32'd2);
        chk("dmc_no_block_read", 32'(rd_q.size() - rb), 32'd0);
        @(negedge clock);
        chk("dmc_rdy_after_ack", 32'(rdy), 32'd1);
        chk("dmc_busy_stays_low", 32'(busy_cnt - bb), 32'd0);
        step();
    endtask

    initial begin
        int wb, ob, guard;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i);

        repeat (3) step();
        reset = 1'b0;
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_owns", 32'(dma_owns_bus), 32'd0);
        chk("rst_bus_rw", 32'(bus_rw), 32'd1);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_bus_data", 32'(bus_data_out), 32'd0);
        chk("rst_dmc_ack", 32'(dmc_ack), 32'd0);
        chk("rst_dmc_data", 32'(dmc_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();

        run_block(8'h02, 1'b0, 0, 1'b0);
        run_block(8'h02, 1'b1, 0, 1'b0);
        run_block(8'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 3, 1'b0);
        run_block(8'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 0, 1'b1);
        run_dmc(DMC_A);
        run_dmc(16'($urandom_range(16'hC000, 16'hFFFF)));

        // Abort a transfer with reset part-way through.
        wb = wr_q.size();
        cpu_rw = 1'b0; cpu_addr = TRIG; cpu_data_out = 8'h11;
        step();
        cpu_rw = 1'b1; cpu_addr = IDLE_A;
        guard = 0;
        while ((wr_q.size() - wb) < 100 && guard < 1000) begin step(); guard++; end
        chk("abort_reached_idx100", 32'(wr_q.size() - wb), 32'd100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_rdy", 32'(rdy), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_owns", 32'(dma_owns_bus), 32'd0);
        ob = own_cnt;
        repeat (20) step();
        chk("abort_bus_quiet", 32'(own_cnt - ob), 32'd0);
        run_block(8'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
